// File: rtl/mem_arbiter.sv
// Main-memory port arbiter for the write buffer, D-cache refill and I-cache refill.
// Fixed priority with an aging override for refills and a per-transfer watchdog.
module mem_arbiter #(
    parameter int AW      = 27,
    parameter int MAXWAIT = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          swc,
    input  logic          wbreq,
    input  logic [AW-1:0] wbadr,
    input  logic [31:0]   wbdata,
    input  logic [3:0]    wbbyteen,
    output logic          wbdone,
    input  logic          dreq,
    input  logic [AW-1:0] dadr,
    output logic          ddone,
    input  logic          ireq,
    input  logic [AW-1:0] iadr,
    output logic          idone,
    output logic [31:0]   readdata,
    output logic          err,
    output logic [AW-1:0] memadr,
    output logic [31:0]   memwdata,
    output logic [3:0]    membyteen,
    output logic          memrwb,
    output logic          memen,
    input  logic [31:0]   memrdata,
    input  logic          memdone
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GWB  = 2'b01,
        GD   = 2'b10,
        GI   = 2'b11
    } state_t;

    localparam logic [3:0] MAXW = 4'(MAXWAIT);
    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_dWait;
    logic [3:0] r_iWait;
    logic [7:0] r_tcnt;

    logic   w_dAged;
    logic   w_iAged;
    logic   w_prefReq;
    logic   w_othReq;
    logic   w_prefAged;
    logic   w_othAged;
    state_t w_prefGrant;
    state_t w_othGrant;
    logic   w_busy;
    logic   w_timeout;
    logic   w_finish;

    assign w_dAged     = dreq && (r_dWait == MAXW);
    assign w_iAged     = ireq && (r_iWait == MAXW);
    assign w_prefReq   = swc ? ireq : dreq;
    assign w_othReq    = swc ? dreq : ireq;
    assign w_prefAged  = swc ? w_iAged : w_dAged;
    assign w_othAged   = swc ? w_dAged : w_iAged;
    assign w_prefGrant = swc ? GI : GD;
    assign w_othGrant  = swc ? GD : GI;

    assign w_busy    = (r_state != IDLE);
    assign w_timeout = w_busy && !memdone && (r_tcnt == TMAX);
    assign w_finish  = w_busy && (memdone || w_timeout);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grants are decided only from IDLE; every transfer returns to IDLE for at least one cycle.
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) begin
            if (w_prefAged) begin
                w_next = w_prefGrant;
            end else if (w_othAged) begin
                w_next = w_othGrant;
            end else if (wbreq) begin
                w_next = GWB;
            end else if (w_prefReq) begin
                w_next = w_prefGrant;
            end else if (w_othReq) begin
                w_next = w_othGrant;
            end
        end else if (w_finish) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        memadr    = '0;
        memwdata  = '0;
        membyteen = 4'b0000;
        memrwb    = 1'b1;
        wbdone    = 1'b0;
        ddone     = 1'b0;
        idone     = 1'b0;
        case (r_state)
            GWB: begin
                memadr    = wbadr;
                memwdata  = wbdata;
                membyteen = wbbyteen;
                memrwb    = 1'b0;
                wbdone    = w_finish;
            end
            GD: begin
                memadr    = dadr;
                membyteen = 4'b1111;
                ddone     = w_finish;
            end
            GI: begin
                memadr    = iadr;
                membyteen = 4'b1111;
                idone     = w_finish;
            end
            default: ;
        endcase
    end

    assign memen    = w_busy;
    assign err      = w_timeout;
    assign readdata = memrdata;

    // A waiting refill ages while another requester holds the port; it holds at zero while served.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_dWait <= 4'd0;
            r_iWait <= 4'd0;
        end else begin
            if (!dreq || (r_state == IDLE && w_next == GD)) begin
                r_dWait <= 4'd0;
            end else if (r_state != GD && r_dWait != MAXW) begin
                r_dWait <= r_dWait + 4'd1;
            end
            if (!ireq || (r_state == IDLE && w_next == GI)) begin
                r_iWait <= 4'd0;
            end else if (r_state != GI && r_iWait != MAXW) begin
                r_iWait <= r_iWait + 4'd1;
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_tcnt <= 8'd0;
        end else if (r_state == IDLE || w_finish) begin
            r_tcnt <= 8'd0;
        end else if (!memdone) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts each
// grant and completion; a monitor compares the DUT's memory port and done pulses against it.
module tb_mem_arbiter;

    localparam int AW      = 27;
    localparam int MAXWAIT = 8;
    localparam int TIMEOUT = 255;

    logic          ph1 = 1'b0;
    logic          reset = 1'b0;
    logic          swc = 1'b0;
    logic          wbreq;
    logic [AW-1:0] wbadr;
    logic [31:0]   wbdata = '0;
    logic [3:0]    wbbyteen = 4'h0;
    logic          wbdone;
    logic          dreq;
    logic [AW-1:0] dadr;
    logic          ddone;
    logic          ireq;
    logic [AW-1:0] iadr;
    logic          idone;
    logic [31:0]   readdata;
    logic          err;
    logic [AW-1:0] memadr;
    logic [31:0]   memwdata;
    logic [3:0]    membyteen;
    logic          memrwb;
    logic          memen;
    logic [31:0]   memrdata = '0;
    logic          memdone = 1'b0;

    // Requester index: 0 = write buffer, 1 = D refill, 2 = I refill
    logic          reqOn[3] = '{1'b0, 1'b0, 1'b0};
    logic [AW-1:0] reqAdr[3] = '{'0, '0, '0};
    int            reqStart[3] = '{0, 0, 0};
    logic          doneSeen[3] = '{1'b0, 1'b0, 1'b0};

    assign wbreq = reqOn[0];
    assign dreq  = reqOn[1];
    assign ireq  = reqOn[2];
    assign wbadr = reqAdr[0];
    assign dadr  = reqAdr[1];
    assign iadr  = reqAdr[2];

    mem_arbiter #(.AW(AW), .MAXWAIT(MAXWAIT), .TIMEOUT(TIMEOUT)) dut (
        .ph1(ph1), .reset(reset), .swc(swc),
        .wbreq(wbreq), .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen), .wbdone(wbdone),
        .dreq(dreq), .dadr(dadr), .ddone(ddone),
        .ireq(ireq), .iadr(iadr), .idone(idone),
        .readdata(readdata), .err(err),
        .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen), .memrwb(memrwb),
        .memen(memen), .memrdata(memrdata), .memdone(memdone)
    );

    initial forever #5 ph1 = ~ph1;

    typedef struct {
        int            who;
        logic [AW-1:0] adr;
        logic [31:0]   wdata;
        logic [3:0]    byteen;
        logic [31:0]   rdata;
        int            edgeNo;
    } grant_t;

    grant_t expQ[$];

    int   checks = 0;
    int   errors = 0;
    int   edgeCount = 0;
    int   doneCount = 0;
    logic mBusy = 1'b0;
    int   mCyc = 0;

    int   prob[3] = '{0, 0, 0};
    logic [2:0] raiseMask = 3'b000;
    logic swcRandom = 1'b0;
    logic swcFixed = 1'b0;
    logic noResp = 1'b0;
    int   latMin = 0;
    int   latMax = 0;
    int   rstHold = 3;
    logic pendingRelease = 1'b0;
    logic inGrant = 1'b0;
    int   waitLeft = 0;
    logic memenPrev = 1'b0;

    function automatic logic [31:0] memValue(input logic [AW-1:0] a);
        return 32'hBEADBEEF ^ (32'(a) * 32'h9E3779B1);
    endfunction

    // Spec-level priority: aged preferred, aged other, write buffer, preferred, other.
    function automatic int pickWinner(input int e);
        int pref;
        int oth;
        pref = swc ? 2 : 1;
        oth  = 3 - pref;
        if (reqOn[pref] && (e - reqStart[pref]) >= MAXWAIT) return pref;
        if (reqOn[oth] && (e - reqStart[oth]) >= MAXWAIT) return oth;
        if (reqOn[0]) return 0;
        if (reqOn[pref]) return pref;
        if (reqOn[oth]) return oth;
        return -1;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    // Reference model: one transaction at a time, decided at the edge after idle.
    initial begin
        int w;
        grant_t g;
        forever begin
            @(posedge ph1);
            edgeCount++;
            if (reset) begin
                if (mBusy) begin
                    mCyc++;
                    if (memdone || mCyc == TIMEOUT + 1) mBusy = 1'b0;
                end else begin
                    w = pickWinner(edgeCount);
                    if (w >= 0) begin
                        g.who    = w;
                        g.adr    = reqAdr[w];
                        g.wdata  = (w == 0) ? wbdata : 32'h0;
                        g.byteen = (w == 0) ? wbbyteen : 4'hF;
                        g.rdata  = memValue(reqAdr[w]);
                        g.edgeNo = edgeCount;
                        expQ.push_back(g);
                        mBusy = 1'b1;
                        mCyc  = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus();
        logic anyOn;
        if (rstHold > 0) begin
            reset = 1'b0;
            rstHold--;
            pendingRelease = 1'b1;
            mBusy = 1'b0;
            mCyc = 0;
            expQ.delete();
            memdone = 1'b0;
            inGrant = 1'b0;
            return;
        end
        if (pendingRelease) begin
            reset = 1'b1;
            pendingRelease = 1'b0;
            for (int i = 0; i < 3; i++) if (reqOn[i]) reqStart[i] = edgeCount + 1;
        end
        if (memen) begin
            if (!inGrant) begin
                inGrant = 1'b1;
                waitLeft = $urandom_range(latMax, latMin);
            end
            if (!noResp && waitLeft == 0) begin
                memdone = 1'b1;
                memrdata = memValue(memadr);
            end else begin
                memdone = 1'b0;
                memrdata = $urandom;
                if (waitLeft > 0) waitLeft--;
            end
        end else begin
            inGrant = 1'b0;
            memdone = ($urandom_range(7) == 0);
            memrdata = $urandom;
        end
        if (swcRandom) begin
            if ($urandom_range(7) == 0) swc = ~swc;
        end else begin
            swc = swcFixed;
        end
        anyOn = reqOn[0] | reqOn[1] | reqOn[2];
        for (int i = 0; i < 3; i++) begin
            if (reqOn[i]) begin
                if (doneSeen[i]) begin
                    reqOn[i] = 1'b0;
                    doneSeen[i] = 1'b0;
                end
            end else if ((raiseMask[i] && !anyOn) || $urandom_range(99) < prob[i]) begin
                reqOn[i] = 1'b1;
                reqAdr[i] = AW'($urandom);
                reqStart[i] = edgeCount + 1;
                if (i == 0) begin
                    wbdata = $urandom;
                    wbbyteen = 4'($urandom_range(15, 1));
                end
            end
        end
        if (!anyOn) raiseMask = 3'b000;
    endtask

    task automatic checkOutput();
        grant_t g;
        logic expDone;
        logic expErr;
        logic [2:0] expDones;
        checkVal("memen", 32'(memen), 32'(mBusy));
        if (mBusy) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got empty queue, expected a pending grant");
            end else begin
                g = expQ[0];
                if (!memenPrev) checkVal("grant_edge", 32'(edgeCount), 32'(g.edgeNo));
                checkVal("memadr", 32'(memadr), 32'(g.adr));
                checkVal("memwdata", memwdata, g.wdata);
                checkVal("membyteen", 32'(membyteen), 32'(g.byteen));
                checkVal("memrwb", 32'(memrwb), (g.who == 0) ? 32'd0 : 32'd1);
                expErr   = !memdone && (mCyc + 1 == TIMEOUT + 1);
                expDone  = memdone || expErr;
                expDones = expDone ? 3'(1 << g.who) : 3'b000;
                checkVal("done", 32'({idone, ddone, wbdone}), 32'(expDones));
                checkVal("err", 32'(err), 32'(expErr));
                if (expDone && !expErr) checkVal("readdata", readdata, g.rdata);
                if (expDone) begin
                    doneSeen[g.who] = 1'b1;
                    void'(expQ.pop_front());
                    doneCount++;
                end
            end
        end else begin
            checkVal("idle_memadr", 32'(memadr), 32'h0);
            checkVal("idle_memwdata", memwdata, 32'h0);
            checkVal("idle_membyteen", 32'(membyteen), 32'h0);
            checkVal("idle_memrwb", 32'(memrwb), 32'h1);
            checkVal("idle_done", 32'({idone, ddone, wbdone, err}), 32'h0);
        end
        memenPrev = memen;
    endtask

    initial forever begin
        @(negedge ph1);
        applyStimulus();
    end

    initial forever begin
        @(negedge ph1);
        #1;
        checkOutput();
    end

    task automatic waitDones(input int n, input int budget, input string name);
        int target;
        target = doneCount + n;
        for (int c = 0; c < budget; c++) begin
            @(negedge ph1);
            if (doneCount >= target) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d completions, expected %0d within %0d cycles",
                 name, doneCount, target, budget);
    endtask

    initial begin
        logic seen;
        repeat (6) @(negedge ph1);

        // Single D refill with two-cycle memory latency
        latMin = 2; latMax = 2;
        raiseMask = 3'b010;
        waitDones(1, 50, "single_d");
        repeat (3) @(negedge ph1);

        // All three at once, both swap settings
        latMin = 0; latMax = 0;
        swcFixed = 1'b0;
        raiseMask = 3'b111;
        waitDones(3, 100, "all_swc0");
        repeat (3) @(negedge ph1);
        swcFixed = 1'b1;
        raiseMask = 3'b111;
        waitDones(3, 100, "all_swc1");
        repeat (3) @(negedge ph1);

        // Continuous write-buffer traffic forces D to age past it
        swcFixed = 1'b0;
        latMin = 0; latMax = 3;
        prob = '{100, 100, 0};
        repeat (300) @(negedge ph1);
        prob = '{0, 0, 0};
        repeat (20) @(negedge ph1);

        // Hung I refill trips the watchdog
        noResp = 1'b1;
        raiseMask = 3'b100;
        waitDones(1, 400, "abort_i");
        repeat (3) @(negedge ph1);

        // Reset in the middle of a D grant
        raiseMask = 3'b010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge ph1);
            seen = memen;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL reset_grant: got memen=0, expected a D grant within 20 cycles");
        end
        repeat (3) @(negedge ph1);
        rstHold = 2;
        noResp = 1'b0;
        latMin = 1; latMax = 1;
        waitDones(1, 50, "reset_regrant");

        // Random traffic
        latMin = 0; latMax = 3;
        swcRandom = 1'b1;
        prob = '{25, 25, 25};
        repeat (2500) @(negedge ph1);

        prob = '{0, 0, 0};
        for (int c = 0; c < 200; c++) begin
            @(negedge ph1);
            if (!(reqOn[0] | reqOn[1] | reqOn[2]) && expQ.size() == 0 && !memen) break;
        end
        repeat (2) @(negedge ph1);
        checkVal("drain_queue", 32'(expQ.size()), 32'h0);
        checkVal("drain_reqs", 32'({reqOn[2], reqOn[1], reqOn[0]}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "[TB] time limit");
    end

endmodule
